// File: rtl/mem_port_arbiter.sv
// Shares one DRAM port between icache and dcache miss traffic using alternating
// priority, with a per-transaction watchdog and the core-wide miss stall.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_rw,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_done,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              cache_miss_stall,
    output logic              mem_err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} state_t;

    state_t              state_reg, state_next;
    logic                last_grant_d_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                mem_valid_reg;
    logic                mem_rw_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [LINE_W-1:0]   mem_wdata_reg;
    logic [LINE_W-1:0]   ic_rdata_reg;
    logic [LINE_W-1:0]   dc_rdata_reg;
    logic                mem_err_reg;

    logic grant_d;
    logic serving;
    logic timed_out;

    // On a tie the side that did not win last time gets the port.
    assign grant_d   = dc_req & (~ic_req | ~last_grant_d_reg);
    assign serving   = (state_reg == SERVE_I) || (state_reg == SERVE_D);
    assign timed_out = ~mem_ready && (cnt_reg == CNT_W'(TIMEOUT));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ic_req || dc_req) state_next = grant_d ? SERVE_D : SERVE_I;
            SERVE_I,
            SERVE_D: if (mem_ready || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: request latching, response capture and watchdog
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_d_reg <= 1'b1;
            cnt_reg          <= '0;
            mem_valid_reg    <= 1'b0;
            mem_rw_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            mem_wdata_reg    <= '0;
            ic_rdata_reg     <= '0;
            dc_rdata_reg     <= '0;
            mem_err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ic_req || dc_req) begin
                        mem_valid_reg <= 1'b1;
                        cnt_reg       <= '0;
                        mem_rw_reg    <= grant_d ? dc_rw : 1'b0;
                        mem_addr_reg  <= grant_d ? dc_addr : ic_addr;
                        mem_wdata_reg <= grant_d ? dc_wdata : '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_ready || timed_out) begin
                        mem_valid_reg    <= 1'b0;
                        last_grant_d_reg <= (state_reg == SERVE_D);
                        if (timed_out) mem_err_reg <= 1'b1;
                        // Writes and aborted transactions return an all-zero line.
                        if (state_reg == SERVE_D)
                            dc_rdata_reg <= (mem_rw_reg || timed_out) ? '0 : mem_rdata;
                        else
                            ic_rdata_reg <= timed_out ? '0 : mem_rdata;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        ic_done = (state_reg == RESP) && !last_grant_d_reg;
        dc_done = (state_reg == RESP) &&  last_grant_d_reg;
        // The completed side's request is still high during its done cycle;
        // masking it lets the core advance in that cycle.
        cache_miss_stall = (ic_req & ~ic_done) | (dc_req & ~dc_done) | serving;
    end

    assign mem_valid = mem_valid_reg;
    assign mem_rw    = mem_rw_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign ic_rdata  = ic_rdata_reg;
    assign dc_rdata  = dc_rdata_reg;
    assign mem_err   = mem_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter: a transaction table plus
// hand-written sequences for timeout, reset abort and spurious ready.
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 16;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_done;
    logic [LINE_W-1:0] ic_rdata;
    logic              dc_req;
    logic              dc_rw;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_wdata;
    logic              dc_done;
    logic [LINE_W-1:0] dc_rdata;
    logic              mem_valid;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_rdata;
    logic              cache_miss_stall;
    logic              mem_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_rw(dc_rw), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_done(dc_done), .dc_rdata(dc_rdata),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .cache_miss_stall(cache_miss_stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              ic_req;
        logic              dc_req;
        logic              dc_rw;
        logic [ADDR_W-1:0] ic_addr;
        logic [ADDR_W-1:0] dc_addr;
        logic [LINE_W-1:0] dc_wdata;
        int                lat;
        logic [LINE_W-1:0] mrdata;
        logic              exp_d;
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_rw;
        logic [LINE_W-1:0] exp_wdata;
        logic [LINE_W-1:0] exp_rdata;
        logic              exp_stall;
    } txn_t;

    localparam logic [LINE_W-1:0] PAT_A = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [LINE_W-1:0] FILL  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    txn_t vec [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic icr, input logic dcr, input logic rw,
                                input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                                input logic [LINE_W-1:0] wd, input int lat,
                                input logic [LINE_W-1:0] mrd, input logic ed,
                                input logic [ADDR_W-1:0] ea, input logic erw,
                                input logic [LINE_W-1:0] ewd, input logic [LINE_W-1:0] erd,
                                input logic est);
        txn_t t;
        t.ic_req = icr; t.dc_req = dcr; t.dc_rw = rw; t.ic_addr = ia; t.dc_addr = da;
        t.dc_wdata = wd; t.lat = lat; t.mrdata = mrd; t.exp_d = ed; t.exp_addr = ea;
        t.exp_rw = erw; t.exp_wdata = ewd; t.exp_rdata = erd; t.exp_stall = est;
        return t;
    endfunction

    // Starts in IDLE (sampled #1 after an edge), ends in IDLE with requests dropped.
    task automatic run_txn(input txn_t r, input logic exp_err, input int idx);
        ic_req = r.ic_req; ic_addr = r.ic_addr;
        dc_req = r.dc_req; dc_rw = r.dc_rw; dc_addr = r.dc_addr; dc_wdata = r.dc_wdata;
        step();
        check("serve_valid", mem_valid, 1'b1);
        check("serve_addr", mem_addr, r.exp_addr);
        check("serve_rw", mem_rw, r.exp_rw);
        check("serve_wdata", mem_wdata, r.exp_wdata);
        check("serve_stall", cache_miss_stall, 1'b1);
        repeat (r.lat) step();
        check("pre_ready_valid", mem_valid, 1'b1);
        mem_ready = 1'b1; mem_rdata = r.mrdata;
        step();
        mem_ready = 1'b0; mem_rdata = '0;
        check("resp_win_done", r.exp_d ? dc_done : ic_done, 1'b1);
        check("resp_lose_done", r.exp_d ? ic_done : dc_done, 1'b0);
        check("resp_rdata", r.exp_d ? dc_rdata : ic_rdata, r.exp_rdata);
        check("resp_stall", cache_miss_stall, r.exp_stall);
        check("resp_valid", mem_valid, 1'b0);
        check("resp_err", mem_err, exp_err);
        ic_req = 1'b0; dc_req = 1'b0;
        step();
        check("idle_done", {ic_done, dc_done}, 2'b00);
        $display("txn %0d: winner=%s addr=%h rw=%0b rdata=%h", idx, r.exp_d ? "D" : "I",
                 mem_addr, mem_rw, r.exp_d ? dc_rdata : ic_rdata);
    endtask

    initial begin
        int n;
        // Alternating ties (from reset, so I first), then single-requester cases.
        vec[0] = mk(1, 1, 0, 16'h1000, 16'h2000, PAT_A, 0, 128'h11, 0, 16'h1000, 0, '0, 128'h11, 1);
        vec[1] = mk(1, 1, 1, 16'h1000, 16'h2000, PAT_A, 1, 128'h22, 1, 16'h2000, 1, PAT_A, '0, 1);
        vec[2] = mk(1, 1, 0, 16'h1100, 16'h2100, '0, 0, 128'h33, 0, 16'h1100, 0, '0, 128'h33, 1);
        vec[3] = mk(1, 1, 0, 16'h1100, 16'h2100, '0, 2, 128'h44, 1, 16'h2100, 0, '0, 128'h44, 1);
        vec[4] = mk(1, 0, 0, 16'h0040, 16'h0000, '0, 2, FILL, 0, 16'h0040, 0, '0, FILL, 0);
        vec[5] = mk(0, 1, 1, 16'h0000, 16'h1F00, PAT_A, 1, 128'h55, 1, 16'h1F00, 1, PAT_A, '0, 0);
        vec[6] = mk(0, 1, 0, 16'h0000, 16'h3FFC, '0, 0, 128'h66, 1, 16'h3FFC, 0, '0, 128'h66, 0);
        vec[7] = mk(1, 0, 0, 16'hFFC0, 16'h0000, '0, TIMEOUT, 128'h77, 0, 16'hFFC0, 0, '0, 128'h77, 0);

        reset = 1'b0; ic_req = 0; ic_addr = '0; dc_req = 0; dc_rw = 0; dc_addr = '0;
        dc_wdata = '0; mem_ready = 0; mem_rdata = '0;
        step(); step();
        check("rst_outputs", {ic_done, dc_done, mem_valid, mem_rw, cache_miss_stall, mem_err}, 6'b0);
        check("rst_addr", mem_addr, '0);
        check("rst_rdata", ic_rdata | dc_rdata | mem_wdata, '0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_txn(vec[i], 1'b0, i);

        // Writeback with address/direction changing mid-service.
        dc_req = 1; dc_rw = 1; dc_addr = 16'h1F00; dc_wdata = PAT_A;
        step();
        check("wb_valid", mem_valid, 1'b1);
        dc_addr = 16'h0000; dc_rw = 0; dc_wdata = '0;
        step(); step();
        check("wb_addr_hold", mem_addr, 16'h1F00);
        check("wb_rw_hold", mem_rw, 1'b1);
        check("wb_wdata_hold", mem_wdata, PAT_A);
        mem_ready = 1; mem_rdata = 128'h99;
        step();
        mem_ready = 0;
        check("wb_done", dc_done, 1'b1);
        check("wb_rdata", dc_rdata, '0);
        dc_req = 0;
        step();
        $display("txn wb-hold: addr=%h rw=%0b", mem_addr, mem_rw);

        // Watchdog timeout: DRAM never answers.
        ic_req = 1; ic_addr = 16'h0123;
        step();
        check("to_valid", mem_valid, 1'b1);
        n = 0;
        while (!ic_done && n < 400) begin
            step();
            n++;
        end
        check("to_cycles", n, TIMEOUT + 1);
        check("to_done", ic_done, 1'b1);
        check("to_err", mem_err, 1'b1);
        check("to_rdata", ic_rdata, '0);
        check("to_valid_drop", mem_valid, 1'b0);
        ic_req = 0;
        step();
        $display("txn timeout: cycles=%0d mem_err=%0b", n, mem_err);
        run_txn(vec[6], 1'b1, 100);

        // Reset while a dcache fill is in flight.
        dc_req = 1; dc_rw = 0; dc_addr = 16'h0200;
        step(); step();
        check("pre_rst_valid", mem_valid, 1'b1);
        reset = 0; dc_req = 0;
        step();
        reset = 1;
        check("rst_mid_valid", mem_valid, 1'b0);
        check("rst_mid_done", dc_done, 1'b0);
        check("rst_mid_err", mem_err, 1'b0);
        check("rst_mid_stall", cache_miss_stall, 1'b0);
        step();
        check("rst_mid_done2", {ic_done, dc_done, mem_valid}, 3'b000);
        $display("txn reset-abort: mem_valid=%0b mem_err=%0b", mem_valid, mem_err);
        run_txn(vec[6], 1'b0, 101);

        // Spurious mem_ready while idle.
        mem_ready = 1; mem_rdata = 128'hBAD;
        step();
        mem_ready = 0;
        check("spur_done", {ic_done, dc_done}, 2'b00);
        check("spur_valid_stall", {mem_valid, cache_miss_stall}, 2'b00);
        step();
        check("spur_done2", {ic_done, dc_done}, 2'b00);
        check("spur_ic_rdata", ic_rdata, '0);
        check("spur_dc_rdata", dc_rdata, 128'h66);
        $display("txn spurious-ready: done=%0b%0b", ic_done, dc_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
